regfile_read_arbiter: RTL and testbench
=======================================

Name: regfile_read_arbiter

Overview:
- Shares the single register-file read port (32-entry × 32-bit, 5-bit select, combinational read) among NUM_REQ requesters.
- Each cycle it picks one request by round-robin and drives the read select.
- It registers the read data into a tagged response one cycle later.
- It forwards same-cycle write data and forces register 0 to read zero. Sits between the decode/operand-fetch requesters and the register file.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, register width
ADDR_WIDTH, 5, register index width
ZERO_REG, 1, 1 = index 0 always reads 0

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
Req  input  NUM_REQ  per-requester read request, level; held until granted
ReqAddr  input  NUM_REQ*ADDR_WIDTH  packed read indices; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
Grant  output  NUM_REQ  one-hot combinational grant in the current cycle
Select  output  ADDR_WIDTH  read index driven to register-file mux
RdData  input  DATA_WIDTH  register-file mux output for Select
WrEn  input  1  register-file write strobe this cycle
WrAddr  input  ADDR_WIDTH  register-file write index
WrData  input  DATA_WIDTH  register-file write data
RespValid  output  1  registered response valid
RespId  output  log2(NUM_REQ) (min 1)  index of requester the response belongs to
RespData  output  DATA_WIDTH  registered read result

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on Reset_n.
- Reset values: RespValid=0, RespId=0, RespData=0, priority pointer Ptr=0.
- While Reset_n=0, Grant=0 and Select=0 (gated combinationally).
- Arbitration (combinational, cycle N):
  - Scan Req starting at index Ptr, wrapping modulo NUM_REQ.
  - The first set bit wins. Grant is one-hot on the winner.
  - Select = ReqAddr slice of the winner. With no request, Grant=0 and Select=0.
- Pointer update at edge ending cycle N: if any grant went to requester i, Ptr <= (i+1) mod NUM_REQ. Otherwise Ptr is unchanged.
- Fairness: a continuously held request is granted within NUM_REQ cycles.
- Handshake:
  - A request is accepted at the rising edge where its Grant=1.
  - The requester then drops Req or presents a new ReqAddr in the following cycle.
  - A request deasserted before its grant is dropped silently.
- Response (latency 1): at the edge ending cycle N, RespValid <= |Grant and RespId <= winner index.
- RespData <= value chosen in cycle N, by priority:
  - ZERO_REG=1 and Select=0 -> 0.
  - Else WrEn=1 and WrAddr==Select -> WrData (write-through forwarding, reads see same-cycle write).
  - Else RdData.
- With no grant, RespValid <= 0; RespData and RespId hold their previous values.
- Back-to-back: one grant per cycle sustained; RespValid may stay high on consecutive cycles with differing RespId.
- Simultaneous events:
  - A write to index 0 is never forwarded when ZERO_REG=1.
  - Multiple requesters with the same ReqAddr are still serialised, one per cycle.
- Reset mid-operation: an outstanding response is discarded (RespValid drops immediately), Ptr returns to 0, and arbitration resumes from requester 0 after Reset_n rises.
- No internal buffering; the requester must sample RespData in the cycle RespValid=1.

Test Plan:
- Reset: Reset_n=0 with Req=4'b1111 -> Grant=0, Select=0, RespValid=0. Release, next cycle -> Grant=4'b0001.
- Round-robin: Req=4'b1111 held 8 cycles, ReqAddr={5'd4,5'd3,5'd2,5'd1}, RdData model returns index*16 -> Grant 0001,0010,0100,1000,0001...; RespId 0,1,2,3,0,..., RespData 16,32,48,64,16,..., each one cycle after its grant.
- Pointer skip: Ptr=1 (after granting 0), Req=4'b1001 -> Grant=4'b1000, next Ptr=0. Next cycle Req=4'b1001 -> Grant=4'b0001.
- Forwarding/zero:
  - Requester 2 reads index 7, RdData=0xAAAA_AAAA, WrEn=1, WrAddr=7, WrData=0x1234_5678 -> RespData=0x1234_5678, RespId=2.
  - Read of index 0 with RdData=0xFFFF_FFFF and WrEn=1, WrAddr=0 -> RespData=0.
- Idle gap: Req=0 for 3 cycles after a grant -> RespValid=0 those cycles, RespData holds last value, Ptr unchanged.
- Async reset mid-stream: assert Reset_n=0 between edges while RespValid=1 -> RespValid=0 immediately, without waiting for Clk. After release with Req=4'b0110 -> Grant=4'b0010.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ requesters.
// Registers a tagged response one cycle after the grant, with write forwarding and a hard-wired zero register.
module regfile_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [NUM_REQ-1:0]            Req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] ReqAddr,
    output logic [NUM_REQ-1:0]            Grant,
    output logic [ADDR_WIDTH-1:0]         Select,
    input  logic [DATA_WIDTH-1:0]         RdData,
    input  logic                          WrEn,
    input  logic [ADDR_WIDTH-1:0]         WrAddr,
    input  logic [DATA_WIDTH-1:0]         WrData,
    output logic                          RespValid,
    output logic [ID_W-1:0]               RespId,
    output logic [DATA_WIDTH-1:0]         RespData
);

    logic [ID_W-1:0]       r_ptr;
    logic                  r_valid;
    logic [ID_W-1:0]       r_id;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_any;
    logic [ID_W-1:0]       w_win;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ADDR_WIDTH-1:0] w_sel;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign w_addr[g] = ReqAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Index arithmetic modulo NUM_REQ, which need not be a power of two.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base,
                                                input int unsigned      step);
        int unsigned sum;
        sum = 32'(base) + step;
        if (sum >= unsigned'(NUM_REQ)) begin
            sum = sum - unsigned'(NUM_REQ);
        end
        return sum[ID_W-1:0];
    endfunction

    always_comb begin
        logic [ID_W-1:0] cand;
        w_any = 1'b0;
        w_win = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_inc(r_ptr, k);
            if (!w_any && Req[cand]) begin
                w_any = 1'b1;
                w_win = cand;
            end
        end
        // Grant and select are forced idle while reset is held.
        if (!Reset_n) begin
            w_any = 1'b0;
            w_win = '0;
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_any) begin
            w_grant[w_win] = 1'b1;
        end
    end

    assign w_sel = w_any ? w_addr[w_win] : '0;

    // Zero register beats forwarding, so a write to index 0 never leaks through.
    always_comb begin
        w_rd_val = RdData;
        if ((ZERO_REG != 0) && (w_sel == '0)) begin
            w_rd_val = '0;
        end else if (WrEn && (WrAddr == w_sel)) begin
            w_rd_val = WrData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= w_any;
            if (w_any) begin
                r_ptr  <= wrap_inc(w_win, 1);
                r_id   <= w_win;
                r_data <= w_rd_val;
            end
        end
    end

    assign Grant     = w_grant;
    assign Select    = w_sel;
    assign RespValid = r_valid;
    assign RespId    = r_id;
    assign RespData  = r_data;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: a behavioural model checked every cycle plus
// directed vectors with literal expectations.
module tb_regfile_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [N-1:0]  Req;
    logic [N*AW-1:0] ReqAddr;
    logic [N-1:0]  Grant;
    logic [AW-1:0] Select;
    logic [DW-1:0] RdData;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [DW-1:0] WrData;
    logic          RespValid;
    logic [1:0]    RespId;
    logic [DW-1:0] RespData;

    logic [AW-1:0] addr [N];
    logic          rd_ovr_en;
    logic [DW-1:0] rd_override;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 Clk = ~Clk;

    always_comb ReqAddr = {addr[3], addr[2], addr[1], addr[0]};
    // Register file stand-in: entry k holds k*16 unless overridden.
    always_comb RdData = rd_ovr_en ? rd_override : (32'(Select) << 4);

    regfile_read_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .ReqAddr(ReqAddr),
        .Grant(Grant), .Select(Select), .RdData(RdData),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RespValid(RespValid), .RespId(RespId), .RespData(RespData)
    );

    // Model state: priority pointer and last response.
    int          m_ptr   = 0;
    logic        m_valid = 1'b0;
    int          m_id    = 0;
    logic [31:0] m_data  = 32'd0;

    function automatic int exp_winner();
        if (!Reset_n) return -1;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (Req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_value(int w);
        int sel = int'(addr[w]);
        if (sel == 0) return 32'd0;
        if (WrEn && int'(WrAddr) == sel) return WrData;
        if (rd_ovr_en) return rd_override;
        return 32'(sel * 16);
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_ptr = 0; m_valid = 1'b0; m_id = 0; m_data = 32'd0;
        end else begin
            int w;
            w = exp_winner();
            if (w >= 0) begin
                m_data  = exp_value(w);
                m_id    = w;
                m_valid = 1'b1;
                m_ptr   = (w + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            int w;
            w = exp_winner();
            chk("m_grant",  32'(Grant),  (w < 0) ? 32'd0 : (32'd1 << w));
            chk("m_select", 32'(Select), (w < 0) ? 32'd0 : 32'(addr[w]));
            chk("m_valid",  32'(RespValid), 32'(m_valid));
            chk("m_id",     32'(RespId), 32'(m_id));
            chk("m_data",   RespData, m_data);
        end
    end

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b1;
        Req = '1;
        addr[0] = 5'd1; addr[1] = 5'd2; addr[2] = 5'd3; addr[3] = 5'd4;
        rd_ovr_en = 1'b0; rd_override = '0;
        WrEn = 1'b0; WrAddr = '0; WrData = '0;
        #1 Reset_n = 1'b0;
        #1 chk_en = 1'b1;

        @(negedge Clk);
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_select", 32'(Select), 32'd0);
        chk("rst_valid", 32'(RespValid), 32'd0);
        #2 Reset_n = 1'b1;
        #1 chk("rel_grant", 32'(Grant), 32'h1);

        // Round-robin sweep; first grant already happened at the edge after release.
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            chk("rr_grant", 32'(Grant), 32'd1 << (c % 4));
            chk("rr_select", 32'(Select), 32'((c % 4) + 1));
            chk("rr_valid", 32'(RespValid), 32'd1);
            chk("rr_id", 32'(RespId), 32'((c - 1) % 4));
            chk("rr_data", RespData, 32'((((c - 1) % 4) + 1) * 16));
        end

        // Pointer now 1: requester 3 then requester 0.
        next_cycle();
        Req = 4'b1001;
        @(negedge Clk);
        chk("skip_grant3", 32'(Grant), 32'h8);
        chk("skip_sel3", 32'(Select), 32'd4);
        next_cycle();
        @(negedge Clk);
        chk("skip_grant0", 32'(Grant), 32'h1);
        chk("skip_id3", 32'(RespId), 32'd3);
        chk("skip_data3", RespData, 32'd64);

        // Write-through forwarding on requester 2.
        next_cycle();
        Req = 4'b0100; addr[2] = 5'd7;
        rd_ovr_en = 1'b1; rd_override = 32'hAAAA_AAAA;
        WrEn = 1'b1; WrAddr = 5'd7; WrData = 32'h1234_5678;
        @(negedge Clk);
        chk("fwd_grant", 32'(Grant), 32'h4);
        chk("fwd_sel", 32'(Select), 32'd7);

        // Index 0 reads zero even with a colliding write.
        next_cycle();
        Req = 4'b0001; addr[0] = 5'd0;
        rd_override = 32'hFFFF_FFFF;
        WrAddr = 5'd0; WrData = 32'hDEAD_BEEF;
        @(negedge Clk);
        chk("fwd_data", RespData, 32'h1234_5678);
        chk("fwd_id", 32'(RespId), 32'd2);
        chk("zero_grant", 32'(Grant), 32'h1);

        next_cycle();
        Req = 4'b0010; addr[1] = 5'd5;
        rd_ovr_en = 1'b0; WrEn = 1'b0;
        @(negedge Clk);
        chk("zero_data", RespData, 32'd0);
        chk("zero_id", 32'(RespId), 32'd0);

        // Idle gap: response of requester 1 (index 5 -> 80) is held.
        next_cycle();
        Req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("idle_valid", 32'(RespValid), (i == 0) ? 32'd1 : 32'd0);
            chk("idle_data", RespData, 32'd80);
            chk("idle_id", 32'(RespId), 32'd1);
            next_cycle();
        end
        addr[0] = 5'd1; addr[1] = 5'd2; addr[2] = 5'd3; addr[3] = 5'd4;
        Req = 4'b1111;
        @(negedge Clk);
        chk("idle_ptr_grant", 32'(Grant), 32'h4);

        // Async reset while a response is valid.
        next_cycle();
        chk("pre_rst_valid", 32'(RespValid), 32'd1);
        chk("pre_rst_data", RespData, 32'd48);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(RespValid), 32'd0);
        chk("async_grant", 32'(Grant), 32'd0);
        chk("async_data", RespData, 32'd0);
        Req = 4'b0110;
        @(negedge Clk);
        #2 Reset_n = 1'b1;
        #1 chk("post_rst_grant", 32'(Grant), 32'h2);
        chk("post_rst_sel", 32'(Select), 32'd2);
        @(negedge Clk);
        chk("post_rst_id", 32'(RespId), 32'd1);
        chk("post_rst_data", RespData, 32'd32);
        chk("post_rst_grant2", 32'(Grant), 32'h4);
        next_cycle();
        next_cycle();
        @(negedge Clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
